// File: rtl/dcp_dark_channel_if.sv
// Pixel-stream bus for the dark-channel stage. The slave modport is the stage itself.
// When DCP_VSYNC_RESYNC_EN is defined, the bus also carries i_vsync.
interface dcp_dark_channel_if #(
   parameter int DATA_W   = 8,
   parameter int CHANNELS = 3
);
   logic [CHANNELS*DATA_W-1:0] i_pix;
   logic                       i_data_valid;
`ifdef DCP_VSYNC_RESYNC_EN
   logic                       i_vsync;
`endif
   logic [DATA_W-1:0]          o_dark;
   logic                       o_data_valid;
   logic [DATA_W-1:0]          o_atm_light;
   logic                       o_atm_valid;

   modport master (
`ifdef DCP_VSYNC_RESYNC_EN
      output i_vsync,
`endif
      output i_pix,
      output i_data_valid,
      input  o_dark,
      input  o_data_valid,
      input  o_atm_light,
      input  o_atm_valid
   );

   modport slave (
`ifdef DCP_VSYNC_RESYNC_EN
      input  i_vsync,
`endif
      input  i_pix,
      input  i_data_valid,
      output o_dark,
      output o_data_valid,
      output o_atm_light,
      output o_atm_valid
   );
endinterface

// File: rtl/dcp_dark_channel.sv
// Dark-channel stage: per-pixel channel min, line-bounded trailing WIN-pixel min, per-frame max as atmospheric light.
// Optional DCP_VSYNC_RESYNC_EN adds i_vsync, which restarts frame counting.
module dcp_dark_channel #(
   parameter int DATA_W   = 8,
   parameter int CHANNELS = 3,
   parameter int WIN      = 15,
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480
) (
   input logic               pixelclk,
   input logic               reset,
   dcp_dark_channel_if.slave bus
);
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

   logic resync;
`ifdef DCP_VSYNC_RESYNC_EN
   assign resync = bus.i_vsync;
`else
   assign resync = 1'b0;
`endif

   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  cur_col;
   logic [ROW_W-1:0]  cur_row;
   logic [DATA_W-1:0] pix_min;

   // A vsync pixel is taken as pixel (0,0) of a fresh frame.
   assign cur_col = resync ? '0 : col;
   assign cur_row = resync ? '0 : row;

   always_comb begin
      pix_min = bus.i_pix[DATA_W-1:0];
      for (int k = 1; k < CHANNELS; k++) begin
         if (bus.i_pix[k*DATA_W +: DATA_W] < pix_min) begin
            pix_min = bus.i_pix[k*DATA_W +: DATA_W];
         end
      end
   end

   logic              s1_valid;
   logic              s1_eof;
   logic [DATA_W-1:0] s1_min;
   logic [COL_W-1:0]  s1_col;

   always_ff @(posedge pixelclk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_eof   <= 1'b0;
         s1_min   <= '0;
         s1_col   <= '0;
         col      <= '0;
         row      <= '0;
      end else begin
         s1_valid <= bus.i_data_valid;
         if (bus.i_data_valid) begin
            s1_min <= pix_min;
            s1_col <= cur_col;
            s1_eof <= (cur_col == LAST_COL) && (cur_row == LAST_ROW);
            if (cur_col == LAST_COL) begin
               col <= '0;
               row <= (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
            end else begin
               col <= cur_col + 1'b1;
               row <= cur_row;
            end
         end else if (resync) begin
            col <= '0;
            row <= '0;
         end
      end
   end

   logic              line_start;
   logic              frame_end;
   logic [DATA_W-1:0] win_min;
   logic [DATA_W-1:0] dark_next;
   logic [DATA_W-1:0] run_max;
   logic [DATA_W-1:0] frame_max;

   assign line_start = (s1_col == '0);
   assign frame_end  = s1_valid && s1_eof;

   generate
      if (WIN > 1) begin : g_win
         logic [DATA_W-1:0] win_mem [WIN-1];

         // At line start the older entries are refilled with all-ones so the window never spans lines.
         always_ff @(posedge pixelclk) begin
            if (reset) begin
               for (int i = 0; i < WIN-1; i++) begin
                  win_mem[i] <= '1;
               end
            end else if (s1_valid) begin
               win_mem[0] <= s1_min;
               for (int i = 1; i < WIN-1; i++) begin
                  win_mem[i] <= line_start ? '1 : win_mem[i-1];
               end
            end
         end

         always_comb begin
            win_min = '1;
            if (!line_start) begin
               for (int i = 0; i < WIN-1; i++) begin
                  if (win_mem[i] < win_min) begin
                     win_min = win_mem[i];
                  end
               end
            end
         end
      end else begin : g_no_win
         assign win_min = '1;
      end
   endgenerate

   assign dark_next = (s1_min < win_min) ? s1_min : win_min;
   assign frame_max = (dark_next > run_max) ? dark_next : run_max;

   // A vsync discards whatever has accumulated, including the pixel still in stage 1.
   always_ff @(posedge pixelclk) begin
      if (reset) begin
         bus.o_dark       <= '0;
         bus.o_data_valid <= 1'b0;
         bus.o_atm_light  <= '0;
         bus.o_atm_valid  <= 1'b0;
         run_max          <= '0;
      end else begin
         bus.o_data_valid <= s1_valid;
         bus.o_atm_valid  <= frame_end;
         if (s1_valid) begin
            bus.o_dark <= dark_next;
         end
         if (frame_end) begin
            bus.o_atm_light <= frame_max;
         end
         if (resync || frame_end) begin
            run_max <= '0;
         end else if (s1_valid) begin
            run_max <= frame_max;
         end
      end
   end
endmodule

// File: tb/tb_dcp_dark_channel.sv
// Self-checking bench for dcp_dark_channel: directed scenarios plus random traffic against a window/frame model.
// Exercises i_vsync when DCP_VSYNC_RESYNC_EN is defined.
module tb_dcp_dark_channel;
   localparam int DATA_W   = 8;
   localparam int CHANNELS = 3;
   localparam int WIN      = 3;
   localparam int IMG_W    = 4;
   localparam int IMG_H    = 2;
   localparam int PIX_W    = CHANNELS * DATA_W;

   logic pixelclk = 1'b0;
   logic reset    = 1'b1;

   dcp_dark_channel_if #(.DATA_W(DATA_W), .CHANNELS(CHANNELS)) bus ();

   dcp_dark_channel #(
      .DATA_W(DATA_W), .CHANNELS(CHANNELS), .WIN(WIN), .IMG_W(IMG_W), .IMG_H(IMG_H)
   ) dut (
      .pixelclk(pixelclk),
      .reset(reset),
      .bus(bus)
   );

   always #5 pixelclk = ~pixelclk;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;

   int m_col, m_row, frame_max, atm_hold;
   int line_mins [IMG_W];
   logic pend_v, pend_atm_v;
   int pend_dark, pend_atm;
   logic [DATA_W-1:0] seen_dark [$];
   logic [DATA_W-1:0] seen_atm [$];

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic logic [PIX_W-1:0] makePix(input int m);
      logic [PIX_W-1:0] p;
      int pos;
      pos = $urandom_range(CHANNELS-1, 0);
      for (int k = 0; k < CHANNELS; k++) begin
         p[k*DATA_W +: DATA_W] = (k == pos) ? DATA_W'(m) : DATA_W'($urandom_range(255, m));
      end
      return p;
   endfunction

   task automatic modelReset();
      m_col = 0; m_row = 0; frame_max = 0; atm_hold = 0;
      for (int i = 0; i < IMG_W; i++) line_mins[i] = 255;
      pend_v = 1'b0; pend_atm_v = 1'b0; pend_dark = 0; pend_atm = 0;
   endtask

   // One clock of stimulus; checks the result of the previous call's input (two-cycle latency).
   task automatic applyStimulus(input logic v, input int m, input logic vs);
      logic cur_v, cur_atm_v;
      int cur_dark, lo;
      logic [PIX_W-1:0] junk;
      cur_v = v; cur_atm_v = 1'b0; cur_dark = 0;
      if (vs) begin
         m_col = 0; m_row = 0; frame_max = 0;
      end
      if (v) begin
         line_mins[m_col] = m;
         lo = (m_col - WIN + 1 < 0) ? 0 : m_col - WIN + 1;
         cur_dark = m;
         for (int j = lo; j < m_col; j++) begin
            if (line_mins[j] < cur_dark) cur_dark = line_mins[j];
         end
         if (cur_dark > frame_max) frame_max = cur_dark;
         if (m_col == IMG_W-1 && m_row == IMG_H-1) begin
            cur_atm_v = 1'b1;
            atm_hold  = frame_max;
            frame_max = 0;
         end
         m_col++;
         if (m_col == IMG_W) begin
            m_col = 0;
            m_row = (m_row == IMG_H-1) ? 0 : m_row + 1;
         end
      end
      junk = PIX_W'($urandom);
      bus.i_data_valid = v;
      bus.i_pix        = v ? makePix(m) : junk;
`ifdef DCP_VSYNC_RESYNC_EN
      bus.i_vsync      = vs;
`endif
      @(posedge pixelclk);
      #1;
      checkOutput("data_valid", 32'(bus.o_data_valid), 32'(pend_v));
      if (pend_v) checkOutput("dark", 32'(bus.o_dark), pend_dark);
      checkOutput("atm_valid", 32'(bus.o_atm_valid), 32'(pend_atm_v));
      checkOutput("atm_light", 32'(bus.o_atm_light), pend_atm);
      if (bus.o_data_valid === 1'b1) seen_dark.push_back(bus.o_dark);
      if (bus.o_atm_valid === 1'b1) begin
         pulses++;
         seen_atm.push_back(bus.o_atm_light);
      end
      pend_v = cur_v; pend_dark = cur_dark; pend_atm_v = cur_atm_v; pend_atm = atm_hold;
   endtask

   task automatic doReset(input int cycles);
      reset = 1'b1;
      bus.i_data_valid = 1'b0;
      bus.i_pix = '0;
`ifdef DCP_VSYNC_RESYNC_EN
      bus.i_vsync = 1'b0;
`endif
      repeat (cycles) begin
         @(posedge pixelclk);
         #1;
         checkOutput("rst_dark", 32'(bus.o_dark), 0);
         checkOutput("rst_data_valid", 32'(bus.o_data_valid), 0);
         checkOutput("rst_atm_light", 32'(bus.o_atm_light), 0);
         checkOutput("rst_atm_valid", 32'(bus.o_atm_valid), 0);
      end
      reset = 1'b0;
      modelReset();
   endtask

   initial begin
      int line_seq [8];
      int exp_seq [8];
      logic v, vs;
      int m;
      line_seq = '{10, 20, 5, 30, 40, 60, 1, 9};
      exp_seq  = '{10, 10, 5, 5, 40, 40, 1, 1};
      modelReset();
      doReset(2);

      $display("[TB] constant pixel frame");
      seen_dark.delete(); seen_atm.delete(); pulses = 0;
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 50, 1'b0);
      repeat (2) applyStimulus(1'b0, 0, 1'b0);
      checkOutput("const_count", seen_dark.size(), 8);
      checkOutput("const_pulses", pulses, 1);
      checkOutput("const_atm", 32'(bus.o_atm_light), 50);

      $display("[TB] line boundary sequence");
      seen_dark.delete();
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, line_seq[i], 1'b0);
      repeat (2) applyStimulus(1'b0, 0, 1'b0);
      for (int i = 0; i < 8; i++) checkOutput("line_seq", 32'(seen_dark[i]), exp_seq[i]);

      $display("[TB] gapped valid pattern");
      seen_dark.delete();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, line_seq[i], 1'b0);
         applyStimulus(1'b0, 0, 1'b0);
      end
      repeat (2) applyStimulus(1'b0, 0, 1'b0);
      for (int i = 0; i < 8; i++) checkOutput("gap_seq", 32'(seen_dark[i]), exp_seq[i]);

      $display("[TB] back-to-back frames");
      seen_atm.delete(); pulses = 0;
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, (i >= 5 && i <= 7) ? 250 : 7, 1'b0);
      repeat (2) applyStimulus(1'b0, 0, 1'b0);
      checkOutput("b2b_pulses", pulses, 2);
      checkOutput("b2b_atm0", 32'(seen_atm[0]), 250);
      checkOutput("b2b_atm1", 32'(seen_atm[1]), 7);

      $display("[TB] reset mid-frame");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 90, 1'b0);
      doReset(1);
      seen_dark.delete(); pulses = 0;
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 33 + i, 1'b0);
      repeat (2) applyStimulus(1'b0, 0, 1'b0);
      checkOutput("rst_out_count", seen_dark.size(), 8);
      checkOutput("rst_pulses", pulses, 1);

`ifdef DCP_VSYNC_RESYNC_EN
      $display("[TB] vsync resync");
      pulses = 0;
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 20, 1'b0);
      applyStimulus(1'b1, 20, 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 20, 1'b0);
      checkOutput("vsync_no_early_pulse", pulses, 0);
      applyStimulus(1'b1, 20, 1'b0);
      repeat (2) applyStimulus(1'b0, 0, 1'b0);
      checkOutput("vsync_pulses", pulses, 1);
`endif

      $display("[TB] random traffic");
      for (int n = 0; n < 300; n++) begin
         v  = ($urandom_range(3, 0) != 0);
         m  = $urandom_range(255, 0);
         vs = 1'b0;
`ifdef DCP_VSYNC_RESYNC_EN
         vs = ($urandom_range(15, 0) == 0);
`endif
         applyStimulus(v, m, vs);
      end
      repeat (3) applyStimulus(1'b0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
